aes_word_loader: RTL and testbench
==================================

AES_WORD_LOADER -- requirements
Module: aes_word_loader

Interface
REQ-001 Parameter: TIMEOUT_CYCLES, default 64, is the maximum number of cycles AES_en stays high waiting for AES_data_out_valid (legal range 2..255).
REQ-002 AES_clk  input  1  single clock; all state updates on its rising edge.
REQ-003 AES_rst_n  input  1  reset, asynchronous assert, active-low.
REQ-004 in_valid  input  1  upstream word valid.
REQ-005 in_ready  output  1  loader can accept a word.
REQ-006 in_word  input  32  key/data word, most-significant word first.
REQ-007 load_key  input  1  sampled with the first word of a block: 1 means 4 key words precede 4 data words.
REQ-008 AES_en  output  1  core start/enable, registered.
REQ-009 AES_data_in  output  128  assembled plaintext to core, registered.
REQ-010 AES_key_in  output  128  assembled key to core, registered.
REQ-011 AES_data_out_valid  input  1  core result-valid from the downstream AES core.
REQ-012 busy  output  1  high in any state other than IDLE.
REQ-013 timeout_err  output  1  one-cycle pulse when the core fails to respond.

Function
REQ-014 A word transfers on a rising edge with in_valid=1 and in_ready=1; in_ready is 1 only in IDLE, LOAD_KEY and LOAD_DATA.
REQ-015 FSM states: IDLE, LOAD_KEY, LOAD_DATA, RUN.
REQ-016 IDLE, first-word handshake: if the effective load_key is 1, go to LOAD_KEY; otherwise go to LOAD_DATA. In both cases the word is stored as word 0.
REQ-017 A 2-bit word counter selects the slice: word 0 goes to [127:96], word 1 to [95:64], word 2 to [63:32], word 3 to [31:0].
REQ-018 LOAD_KEY: 4 accepted words fill AES_key_in, then go to LOAD_DATA with the counter at 0; key_valid is set.
REQ-019 LOAD_DATA: 4 accepted words fill AES_data_in; on the 4th handshake go to RUN, and AES_en=1 from the next cycle.
REQ-020 AES_data_in and AES_key_in update only on their own word handshakes and are stable throughout RUN.
REQ-021 RUN: AES_en held at 1 while a cycle counter counts the cycles AES_en is high.
REQ-022 RUN, AES_data_out_valid=1 sampled: AES_en=0 the next cycle, go to IDLE, and the counter clears.
REQ-023 RUN: if TIMEOUT_CYCLES cycles with AES_en=1 elapse without valid, pulse timeout_err for one cycle, drive AES_en=0 and go to IDLE.
REQ-024 If valid and timeout coincide in the same cycle, valid wins and timeout_err stays 0.
REQ-025 AES_data_out_valid outside RUN is ignored.
REQ-026 in_valid with in_ready=0 is not consumed; upstream must hold the word.
REQ-027 Back-to-back blocks: a new first word is accepted in the first IDLE cycle after RUN exits.
REQ-028 Latency: with continuous in_valid, AES_en rises 1 cycle after the last data handshake; an 8-word block takes 9 cycles from the first handshake to AES_en=1.

Reset
REQ-029 While AES_rst_n=0, independent of the clock: state=IDLE, in_ready=1 (held low during reset is also acceptable; in_ready=1 only after release), AES_en=0, AES_data_in=0, AES_key_in=0, busy=0, timeout_err=0, counters=0, key_valid=0.
REQ-030 Reset mid-load or mid-RUN discards the partial block; AES_en falls immediately.

Configuration
REQ-031 Macro AES_LOADER_KEY_CACHE_EN defined: effective load_key = load_key OR NOT key_valid, and a block with effective load_key=0 reuses the stored key and takes 4 words.
REQ-032 AES_LOADER_KEY_CACHE_EN undefined: load_key is ignored, key_valid logic is removed, and every block is 8 words (key then data).

Verification
REQ-033 Bench scenarios:
- Reset, then 8 words aa2bdb40, bff6a5e8, caa9ba3e, bc1e2acc, 00000058, 0, 0, 0 with load_key=1 -> AES_key_in=aa2bdb40_bff6a5e8_caa9ba3e_bc1e2acc, AES_data_in=00000058_00000000_00000000_00000000, AES_en=1 9 cycles after the first handshake.
- In RUN, valid pulse on the 30th AES_en cycle -> AES_en=0 the next cycle, busy=0, timeout_err never asserts.
- Core held silent -> AES_en high exactly 64 cycles, timeout_err single pulse, return to IDLE.
- With cache enabled, a second block with load_key=0 and words a6f2daeb, 140fa720, 529e75d5, 21cbc681 -> key unchanged, AES_en after 4 words. With cache disabled, the same block needs 8 words.
- Cache enabled, first block after reset with load_key=0 -> 8 words are consumed (forced key load).
- Reset asserted on the 3rd data word, and separately mid-RUN -> all outputs return to zero asynchronously, and the next block loads correctly.

Source files
------------

// File: rtl/aes_word_loader.sv
// aes_word_loader: packs 32-bit words into AES key/data blocks and runs the core.
// Optional key cache enabled by defining AES_LOADER_KEY_CACHE_EN.
module aes_word_loader #(
  parameter int unsigned TIMEOUT_CYCLES = 64
) (
  input  logic         AES_clk,
  input  logic         AES_rst_n,
  input  logic         in_valid,
  output logic         in_ready,
  input  logic [31:0]  in_word,
  input  logic         load_key,
  output logic         AES_en,
  output logic [127:0] AES_data_in,
  output logic [127:0] AES_key_in,
  input  logic         AES_data_out_valid,
  output logic         busy,
  output logic         timeout_err
);

  typedef enum logic [1:0] {
    IDLE,
    LOAD_KEY,
    LOAD_DATA,
    RUN
  } state_t;

  localparam logic [7:0] TMO_LAST = 8'(TIMEOUT_CYCLES - 1);

  state_t       state_q, state_d;
  logic [1:0]   wcnt_q, wcnt_d;
  logic [7:0]   cyc_q, cyc_d;
  logic         en_d;
  logic         tmo_d;
  logic [127:0] key_d, data_d;
  logic         take;
  logic         eff_key;
  logic         last_word;
  logic         tmo_hit;

  function automatic logic [127:0] put_word(
    input logic [127:0] blk,
    input logic [1:0]   idx,
    input logic [31:0]  w
  );
    logic [127:0] r;
    r = blk;
    case (idx)
      2'd0:    r[127:96] = w;
      2'd1:    r[95:64]  = w;
      2'd2:    r[63:32]  = w;
      default: r[31:0]   = w;
    endcase
    return r;
  endfunction

  assign in_ready  = (state_q != RUN);
  assign busy      = (state_q != IDLE);
  assign take      = in_valid & in_ready;
  assign last_word = (wcnt_q == 2'd3);
  assign tmo_hit   = (cyc_q == TMO_LAST);

`ifdef AES_LOADER_KEY_CACHE_EN
  logic kv_q, kv_d;

  // a block may skip the key only once a key has been captured
  assign eff_key = load_key | ~kv_q;

  always_ff @(posedge AES_clk or negedge AES_rst_n) begin
    if (!AES_rst_n) begin
      kv_q <= 1'b0;
    end else begin
      kv_q <= kv_d;
    end
  end
`else
  logic cfg_unused;

  assign cfg_unused = load_key;
  assign eff_key    = 1'b1;
`endif

  always_comb begin
    state_d = state_q;
    wcnt_d  = wcnt_q;
    cyc_d   = cyc_q;
    en_d    = AES_en;
    tmo_d   = 1'b0;
    key_d   = AES_key_in;
    data_d  = AES_data_in;
`ifdef AES_LOADER_KEY_CACHE_EN
    kv_d    = kv_q;
`endif
    unique case (state_q)
      IDLE: begin
        if (take) begin
          wcnt_d = 2'd1;
          if (eff_key) begin
            key_d   = put_word(AES_key_in, 2'd0, in_word);
            state_d = LOAD_KEY;
          end else begin
            data_d  = put_word(AES_data_in, 2'd0, in_word);
            state_d = LOAD_DATA;
          end
        end
      end
      LOAD_KEY: begin
        if (take) begin
          key_d  = put_word(AES_key_in, wcnt_q, in_word);
          wcnt_d = wcnt_q + 2'd1;
          if (last_word) begin
            state_d = LOAD_DATA;
`ifdef AES_LOADER_KEY_CACHE_EN
            kv_d    = 1'b1;
`endif
          end
        end
      end
      LOAD_DATA: begin
        if (take) begin
          data_d = put_word(AES_data_in, wcnt_q, in_word);
          wcnt_d = wcnt_q + 2'd1;
          if (last_word) begin
            state_d = RUN;
            en_d    = 1'b1;
            cyc_d   = '0;
          end
        end
      end
      RUN: begin
        // a result in the final cycle beats the timeout
        if (AES_data_out_valid) begin
          state_d = IDLE;
          en_d    = 1'b0;
          cyc_d   = '0;
        end else if (tmo_hit) begin
          state_d = IDLE;
          en_d    = 1'b0;
          tmo_d   = 1'b1;
          cyc_d   = '0;
        end else begin
          cyc_d = cyc_q + 8'd1;
        end
      end
      default: begin
        state_d = IDLE;
        en_d    = 1'b0;
        cyc_d   = '0;
        wcnt_d  = '0;
      end
    endcase
  end

  always_ff @(posedge AES_clk or negedge AES_rst_n) begin
    if (!AES_rst_n) begin
      state_q     <= IDLE;
      wcnt_q      <= '0;
      cyc_q       <= '0;
      AES_en      <= 1'b0;
      timeout_err <= 1'b0;
      AES_key_in  <= '0;
      AES_data_in <= '0;
    end else begin
      state_q     <= state_d;
      wcnt_q      <= wcnt_d;
      cyc_q       <= cyc_d;
      AES_en      <= en_d;
      timeout_err <= tmo_d;
      AES_key_in  <= key_d;
      AES_data_in <= data_d;
    end
  end

endmodule

// File: tb/tb_aes_word_loader.sv
// tb_aes_word_loader: directed + randomized checks against a block-level model.
// Follows the DUT build: define AES_LOADER_KEY_CACHE_EN for both or neither.
module tb_aes_word_loader;

  localparam int TMO = 64;

`ifdef AES_LOADER_KEY_CACHE_EN
  localparam bit CACHE = 1'b1;
`else
  localparam bit CACHE = 1'b0;
`endif

  typedef logic [31:0] blk_t [4];

  logic         AES_clk = 1'b0;
  logic         AES_rst_n = 1'b0;
  logic         in_valid = 1'b0;
  logic         in_ready;
  logic [31:0]  in_word = '0;
  logic         load_key = 1'b0;
  logic         AES_en;
  logic [127:0] AES_data_in;
  logic [127:0] AES_key_in;
  logic         AES_data_out_valid = 1'b0;
  logic         busy;
  logic         timeout_err;

  int checks = 0;
  int errors = 0;

  bit   m_kv = 1'b0;
  blk_t m_key = '{default: '0};
  blk_t m_data = '{default: '0};

  aes_word_loader #(.TIMEOUT_CYCLES(TMO)) dut (
    .AES_clk           (AES_clk),
    .AES_rst_n         (AES_rst_n),
    .in_valid          (in_valid),
    .in_ready          (in_ready),
    .in_word           (in_word),
    .load_key          (load_key),
    .AES_en            (AES_en),
    .AES_data_in       (AES_data_in),
    .AES_key_in        (AES_key_in),
    .AES_data_out_valid(AES_data_out_valid),
    .busy              (busy),
    .timeout_err       (timeout_err)
  );

  always #5 AES_clk = ~AES_clk;

  task automatic chk1(input string tag, input logic obs, input logic exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%b expected=%b", tag, obs, exp);
    end
  endtask

  task automatic chkn(input string tag, input int obs, input int exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  task automatic chkw(input string tag, input logic [127:0] obs,
                      input logic [127:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  function automatic logic [127:0] cat4(input blk_t w);
    return {w[0], w[1], w[2], w[3]};
  endfunction

  task automatic rnd4(output blk_t w);
    for (int i = 0; i < 4; i++) w[i] = $urandom;
  endtask

  task automatic tick();
    @(posedge AES_clk);
    #1;
  endtask

  task automatic send_block(input bit lk, input blk_t k, input blk_t d,
                            input bit gaps);
    logic [31:0] words[$];
    bit ld;
    ld = !CACHE || lk || !m_kv;
    if (ld) begin
      for (int i = 0; i < 4; i++) words.push_back(k[i]);
      m_key = k;
      m_kv  = 1'b1;
    end
    for (int i = 0; i < 4; i++) words.push_back(d[i]);
    m_data = d;
    for (int i = 0; i < words.size(); i++) begin
      if (gaps && i > 0 && $urandom_range(0, 1) == 1) begin
        in_valid = 1'b0;
        repeat ($urandom_range(1, 3)) tick();
      end
      in_valid = 1'b1;
      in_word  = words[i];
      load_key = (i == 0) ? lk : 1'($urandom_range(0, 1));
      chk1("in_ready_load", in_ready, 1'b1);
      tick();
      chk1("en_after_word", AES_en, i == words.size() - 1);
      chk1("tmo_during_load", timeout_err, 1'b0);
    end
    in_valid = 1'b0;
    chkw("key_loaded", AES_key_in, cat4(m_key));
    chkw("data_loaded", AES_data_in, cat4(m_data));
    chk1("busy_run", busy, 1'b1);
  endtask

  task automatic run_core(input int valid_at, input bit hold,
                          input logic [31:0] hw, input bit hlk);
    int  c;
    int  pulses;
    int  exp_high;
    bit  answered;
    answered = valid_at >= 1 && valid_at <= TMO;
    exp_high = answered ? valid_at : TMO;
    c = 0;
    pulses = 0;
    if (hold) begin
      in_valid = 1'b1;
      in_word  = hw;
      load_key = hlk;
    end
    chk1("in_ready_run", in_ready, 1'b0);
    while (AES_en === 1'b1 && c < TMO + 4) begin
      c++;
      AES_data_out_valid = (c == valid_at);
      tick();
      if (timeout_err === 1'b1) pulses++;
    end
    AES_data_out_valid = 1'b0;
    chkn("en_cycles", c, exp_high);
    chkn("tmo_pulses", pulses, answered ? 0 : 1);
    chk1("en_off", AES_en, 1'b0);
    chk1("busy_idle", busy, 1'b0);
    chk1("in_ready_idle", in_ready, 1'b1);
    chkw("key_held", AES_key_in, cat4(m_key));
    chkw("data_held", AES_data_in, cat4(m_data));
  endtask

  task automatic check_zero(input string tag);
    chk1({tag, "_en"}, AES_en, 1'b0);
    chkw({tag, "_data"}, AES_data_in, '0);
    chkw({tag, "_key"}, AES_key_in, '0);
    chk1({tag, "_busy"}, busy, 1'b0);
    chk1({tag, "_tmo"}, timeout_err, 1'b0);
  endtask

  task automatic do_reset(input string tag);
    #2 AES_rst_n = 1'b0;
    #1;
    check_zero(tag);
    in_valid = 1'b0;
    AES_data_out_valid = 1'b0;
    m_kv = 1'b0;
    @(posedge AES_clk);
    #3 AES_rst_n = 1'b1;
    tick();
    chk1({tag, "_ready"}, in_ready, 1'b1);
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog expired observed=running expected=finished");
    $fatal(1, "watchdog");
  end

  initial begin
    blk_t k1;
    blk_t d1;
    blk_t d2;
    blk_t ka;
    blk_t da;
    blk_t kb;
    blk_t db;
    bit   lk;
    int   va;
    k1 = '{32'haa2bdb40, 32'hbff6a5e8, 32'hcaa9ba3e, 32'hbc1e2acc};
    d1 = '{32'h00000058, 32'h0, 32'h0, 32'h0};
    d2 = '{32'ha6f2daeb, 32'h140fa720, 32'h529e75d5, 32'h21cbc681};

    #1;
    check_zero("rst_init");
    @(posedge AES_clk);
    #3 AES_rst_n = 1'b1;
    tick();
    chk1("ready_after_rst", in_ready, 1'b1);

    AES_data_out_valid = 1'b1;
    tick();
    AES_data_out_valid = 1'b0;
    chk1("idle_valid_busy", busy, 1'b0);
    chk1("idle_valid_en", AES_en, 1'b0);
    chk1("idle_valid_tmo", timeout_err, 1'b0);

    send_block(1'b1, k1, d1, 1'b0);
    chkw("blk1_key", AES_key_in,
         128'haa2bdb40_bff6a5e8_caa9ba3e_bc1e2acc);
    chkw("blk1_data", AES_data_in,
         128'h00000058_00000000_00000000_00000000);
    run_core(30, 1'b0, 32'h0, 1'b0);

    send_block(1'b0, m_key, d2, 1'b0);
    chkw("blk2_key", AES_key_in,
         128'haa2bdb40_bff6a5e8_caa9ba3e_bc1e2acc);
    chkw("blk2_data", AES_data_in,
         128'ha6f2daeb_140fa720_529e75d5_21cbc681);
    run_core(0, 1'b0, 32'h0, 1'b0);

    rnd4(ka);
    rnd4(da);
    rnd4(kb);
    rnd4(db);
    send_block(1'b1, ka, da, 1'b0);
    run_core(TMO, 1'b1, kb[0], 1'b1);
    send_block(1'b1, kb, db, 1'b0);
    run_core(1, 1'b0, 32'h0, 1'b0);

    rnd4(ka);
    rnd4(da);
    in_valid = 1'b1;
    for (int i = 0; i < 4; i++) begin
      in_word = ka[i];
      load_key = 1'b1;
      tick();
    end
    for (int i = 0; i < 2; i++) begin
      in_word = da[i];
      tick();
    end
    in_word = da[2];
    do_reset("rst_load");

    rnd4(ka);
    rnd4(da);
    send_block(1'b0, ka, da, 1'b0);
    run_core(5, 1'b0, 32'h0, 1'b0);

    rnd4(ka);
    rnd4(da);
    send_block(1'b1, ka, da, 1'b1);
    repeat (3) tick();
    do_reset("rst_run");

    rnd4(ka);
    rnd4(da);
    send_block(1'b1, ka, da, 1'b0);
    run_core(TMO - 1, 1'b0, 32'h0, 1'b0);

    for (int b = 0; b < 6; b++) begin
      rnd4(ka);
      rnd4(da);
      lk = 1'($urandom_range(0, 1));
      va = ($urandom_range(0, 3) == 0) ? 0 : $urandom_range(1, TMO);
      send_block(lk, ka, da, 1'b1);
      run_core(va, 1'b0, 32'h0, 1'b0);
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
